// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and helpers for the parametrised 1R1W masked SRAM with clear
// engine (sram_1r1w_init_array).
//   - sram_state_e     : clear-engine FSM states (SRAM_INIT, SRAM_IDLE)
//   - sram_addr_width  : clog2-based address width, never below 1 bit
//   - sram_merge       : per-segment merge of old/new words under a write mask;
//                        used by both the array write path and the read bypass
// -----------------------------------------------------------------------------
package sram_pkg;

    // Widest entry the merge helper handles. Callers zero-extend into this
    // width and truncate the result back to their own WIDTH.
    localparam int SRAM_MAX_WIDTH = 256;

    typedef enum logic [0:0] {
        SRAM_INIT = 1'b0,
        SRAM_IDLE = 1'b1
    } sram_state_e;

    function automatic int sram_addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // Bit b of the result comes from new_v when the mask bit of its segment
    // (b / gran) is set, otherwise from old_v.
    function automatic logic [SRAM_MAX_WIDTH-1:0] sram_merge(
        input logic [SRAM_MAX_WIDTH-1:0] old_v,
        input logic [SRAM_MAX_WIDTH-1:0] new_v,
        input logic [SRAM_MAX_WIDTH-1:0] mask,
        input int                        gran
    );
        logic [SRAM_MAX_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < SRAM_MAX_WIDTH; b++) begin
            if (mask[b / gran]) begin
                res[b] = new_v[b];
            end
        end
        return res;
    endfunction

endpackage : sram_pkg

// File: rtl/sram_init_ctrl.sv
// -----------------------------------------------------------------------------
// sram_init_ctrl
// Clear-engine FSM for sram_1r1w_init_array. After reset, or on init_req_i
// while idle, it walks every entry 0..DEPTH-1 (one per cycle) and owns the
// array write port while doing so.
// Ports:
//   clock       in   clock
//   reset_n     in   asynchronous active-low reset (forces INIT, counter=0)
//   init_req_i  in   start a full clear (honoured in IDLE only)
//   ready_o     out  1 in IDLE: client accesses are accepted
//   clr_we_o    out  1 in INIT: write-port mux selects the clear engine
//   clr_addr_o  out  entry being cleared this cycle
// -----------------------------------------------------------------------------
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          init_req_i,
    output logic          ready_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    sram_state_e   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SRAM_INIT: begin
                // init_req_i is not looked at here: a clear in progress is
                // never restarted.
                if (cnt_q == LAST_ADDR) begin
                    state_d = SRAM_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SRAM_IDLE: begin
                if (init_req_i) begin
                    state_d = SRAM_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SRAM_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset_n) begin
            state_q <= SRAM_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o    = (state_q == SRAM_IDLE);
    assign clr_we_o   = (state_q == SRAM_INIT);
    assign clr_addr_o = cnt_q;

endmodule : sram_init_ctrl

// File: rtl/sram_1r1w_init_array.sv
// -----------------------------------------------------------------------------
// sram_1r1w_init_array
// Parametrised 1-read/1-write masked SRAM with a hardware clear engine and a
// registered, held read port.
// Configuration macro: SRAM_RW_BYPASS_EN
//   defined   : same-cycle read+write to one address returns the merged word
//   undefined : such a read returns the old contents (write still lands)
// Ports:
//   clock     in   clock
//   reset_n   in   asynchronous active-low reset
//   ready     out  1 when reads/writes are accepted (clear engine idle)
//   init_req  in   start a full clear of the array
//   r_en      in   read request
//   r_addr    in   read address (>= DEPTH reads INIT_VALUE)
//   r_valid   out  one-cycle strobe, r_data updated
//   r_data    out  registered read data, held between reads
//   w_en      in   write request
//   w_addr    in   write address (>= DEPTH ignored)
//   w_data    in   write data
//   w_mask    in   per-segment write enable (MASK_GRAN bits per segment)
// -----------------------------------------------------------------------------
module sram_1r1w_init_array
    import sram_pkg::*;
#(
    parameter  int               DEPTH      = 512,
    parameter  int               WIDTH      = 12,
    parameter  int               MASK_GRAN  = 12,
    parameter  logic [WIDTH-1:0] INIT_VALUE = '0,
    localparam int               AW         = sram_addr_width(DEPTH),
    localparam int               SEGS       = WIDTH / MASK_GRAN
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic             ready,
    input  logic             init_req,
    input  logic             r_en,
    input  logic [AW-1:0]    r_addr,
    output logic             r_valid,
    output logic [WIDTH-1:0] r_data,
    input  logic             w_en,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    input  logic [SEGS-1:0]  w_mask
);

    // One extra bit so DEPTH itself is representable (DEPTH may be 2**AW).
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    function automatic logic [WIDTH-1:0] merge_w(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [SEGS-1:0]  mask
    );
        return WIDTH'(sram_merge(SRAM_MAX_WIDTH'(old_v), SRAM_MAX_WIDTH'(new_v),
                                 SRAM_MAX_WIDTH'(mask), MASK_GRAN));
    endfunction

    // ---------------- clear engine ----------------
    logic          ctrl_ready;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    sram_init_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_ctrl (
        .clock      (clock),
        .reset_n    (reset_n),
        .init_req_i (init_req),
        .ready_o    (ctrl_ready),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign ready = ctrl_ready;

    // ---------------- request qualification ----------------
    logic rd_in_range, wr_in_range;
    logic rd_acc, wr_acc;

    assign rd_in_range = ({1'b0, r_addr} < DEPTH_W);
    assign wr_in_range = ({1'b0, w_addr} < DEPTH_W);
    // Requests while not ready are dropped; init_req in the same IDLE cycle
    // does not cancel them.
    assign rd_acc      = ctrl_ready && r_en;
    assign wr_acc      = ctrl_ready && w_en && wr_in_range;

    // ---------------- write-port mux ----------------
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [SEGS-1:0]  mem_wmask;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = w_addr;
        mem_wdata = w_data;
        mem_wmask = w_mask;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = INIT_VALUE;
            mem_wmask = '1;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    // ---------------- storage ----------------
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is intentionally left out of reset; its contents are
    // defined only by the clear engine, which keeps it mappable to a macro.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= merge_w(mem[mem_waddr], mem_wdata, mem_wmask);
        end
    end

    // ---------------- read path ----------------
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] r_data_d;
    logic [WIDTH-1:0] r_data_q;
    logic             r_valid_q;

    assign rd_word = mem[r_addr];

`ifdef SRAM_RW_BYPASS_EN
    logic rd_hit;
    // Forward the word the same-cycle write is about to store.
    assign rd_hit   = wr_acc && (r_addr == w_addr);
    assign r_data_d = !rd_in_range ? INIT_VALUE :
                      rd_hit       ? merge_w(rd_word, w_data, w_mask) : rd_word;
`else
    assign r_data_d = !rd_in_range ? INIT_VALUE : rd_word;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= rd_acc;
            if (rd_acc) begin
                r_data_q <= r_data_d;
            end
        end
    end

    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;

endmodule : sram_1r1w_init_array
